// File: rtl/lieat_rf_pkg.sv
// Shared constants and types for the multi-port register file.
// Used by lieat_regfile_mp and lieat_rf_sb.
package lieat_rf_pkg;

   localparam int LIEAT_RF_XLEN = 32;
   localparam int LIEAT_RF_NREG = 32;

   function automatic int rf_idxw(input int nreg);
      return (nreg <= 2) ? 1 : $clog2(nreg);
   endfunction

   typedef logic [rf_idxw(LIEAT_RF_NREG)-1:0] rf_idx_t;

endpackage

// File: rtl/lieat_general_dfflr.sv
// Load-enable flop with asynchronous active-low reset to zero.
// Generic storage primitive.
module lieat_general_dfflr #(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          lden,
   input  logic [DW-1:0] dnxt,
   output logic [DW-1:0] qout
);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         qout <= '0;
      else if (lden)
         qout <= dnxt;
   end

endmodule

// File: rtl/lieat_rf_sb.sv
// Long-latency scoreboard: pending bits, set/clear priority, busy lookup.
// Same-cycle clear bypass of busy under LIEAT_REGFILE_BYPASS_EN.
module lieat_rf_sb
   import lieat_rf_pkg::*;
#(
   parameter int NREG = LIEAT_RF_NREG,
   parameter int NRD  = 3,
   parameter int NWR  = 2,
   localparam int IDXW = rf_idxw(NREG)
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [NRD*IDXW-1:0] rd_idx,
   output logic [NRD-1:0]    rd_busy,
   input  logic [NWR-1:0]    wr_en,
   input  logic [NWR*IDXW-1:0] wr_idx,
   input  logic [NWR-1:0]    wr_clr,
   input  logic              sb_set,
   input  logic [IDXW-1:0]   sb_idx,
   output logic              sb_any
);

   logic [NREG-1:1] pend_q;
   logic [NREG-1:1] pend_nxt;
   logic [NREG-1:1] clr_vec;
   logic [NREG-1:0] pend;

   assign pend = {pend_q, 1'b0};

   always_comb begin
      clr_vec = '0;
      for (int r = 1; r < NREG; r++) begin
         for (int k = 0; k < NWR; k++) begin
            if (wr_en[k] && wr_clr[k] &&
                wr_idx[k*IDXW +: IDXW] == IDXW'(r))
               clr_vec[r] = 1'b1;
         end
      end
   end

   // set beats clear: the issuing op is younger than the retiring one
   always_comb begin
      pend_nxt = pend_q & ~clr_vec;
      for (int r = 1; r < NREG; r++) begin
         if (sb_set && sb_idx == IDXW'(r))
            pend_nxt[r] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         pend_q <= '0;
      else
         pend_q <= pend_nxt;
   end

   always_comb begin
      rd_busy = '0;
      for (int p = 0; p < NRD; p++) begin
         logic [IDXW-1:0] ix;
         ix = rd_idx[p*IDXW +: IDXW];
         rd_busy[p] = pend[ix];
`ifdef LIEAT_REGFILE_BYPASS_EN
         if (ix != '0) begin
            for (int k = 0; k < NWR; k++) begin
               if (wr_en[k] && wr_clr[k] &&
                   wr_idx[k*IDXW +: IDXW] == ix &&
                   !(sb_set && sb_idx == ix))
                  rd_busy[p] = 1'b0;
            end
         end
`endif
      end
   end

   assign sb_any = |pend_q;

endmodule

// File: rtl/lieat_regfile_mp.sv
// Multi-port integer register file with long-latency scoreboard.
// Optional same-cycle write bypass: LIEAT_REGFILE_BYPASS_EN.
module lieat_regfile_mp
   import lieat_rf_pkg::*;
#(
   parameter int XLEN = LIEAT_RF_XLEN,
   parameter int NREG = LIEAT_RF_NREG,
   parameter int NRD  = 3,
   parameter int NWR  = 2,
   localparam int IDXW = rf_idxw(NREG)
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic [NRD*IDXW-1:0] rd_idx,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic [NWR-1:0]      wr_en,
   input  logic [NWR*IDXW-1:0] wr_idx,
   input  logic [NWR*XLEN-1:0] wr_data,
   input  logic [NWR-1:0]      wr_clr,
   input  logic                sb_set,
   input  logic [IDXW-1:0]     sb_idx,
   output logic                sb_any
);

   logic [XLEN-1:0] rf [NREG];

   assign rf[0] = '0;

   // higher port overwrites lower: youngest write wins
   for (genvar r = 1; r < NREG; r++) begin : g_reg
      logic            en;
      logic [XLEN-1:0] d;

      always_comb begin
         en = 1'b0;
         d  = '0;
         for (int k = 0; k < NWR; k++) begin
            if (wr_en[k] && wr_idx[k*IDXW +: IDXW] == IDXW'(r)) begin
               en = 1'b1;
               d  = wr_data[k*XLEN +: XLEN];
            end
         end
      end

      lieat_general_dfflr #(
         .DW   (XLEN)
      ) u_dff (
         .clk  (clk),
         .rstn (rstn),
         .lden (en),
         .dnxt (d),
         .qout (rf[r])
      );
   end

   always_comb begin
      rd_data = '0;
      for (int p = 0; p < NRD; p++) begin
         logic [IDXW-1:0] ix;
         logic [XLEN-1:0] v;
         ix = rd_idx[p*IDXW +: IDXW];
         v  = rf[ix];
`ifdef LIEAT_REGFILE_BYPASS_EN
         if (ix != '0) begin
            for (int k = 0; k < NWR; k++) begin
               if (wr_en[k] && wr_idx[k*IDXW +: IDXW] == ix)
                  v = wr_data[k*XLEN +: XLEN];
            end
         end
`endif
         rd_data[p*XLEN +: XLEN] = v;
      end
   end

   lieat_rf_sb #(
      .NREG    (NREG),
      .NRD     (NRD),
      .NWR     (NWR)
   ) u_sb (
      .clk     (clk),
      .rstn    (rstn),
      .rd_idx  (rd_idx),
      .rd_busy (rd_busy),
      .wr_en   (wr_en),
      .wr_idx  (wr_idx),
      .wr_clr  (wr_clr),
      .sb_set  (sb_set),
      .sb_idx  (sb_idx),
      .sb_any  (sb_any)
   );

endmodule

// File: doc/lieat_regfile_mp.md
# lieat_regfile_mp

Parametrised multi-port integer register file with a built-in long-latency scoreboard, for the 7-stage core and its wider-issue follow-ons. It provides NRD combinational read ports and NWR write ports with a fixed write priority. It tracks per-register "pending" bits for long-latency results such as loads and divides, and can forward same-cycle write data to readers. It sits between decode/issue (reads, scoreboard set) and writeback (writes, scoreboard clear).

## Interface
- XLEN, 32, data width
- NREG, 32, number of architectural registers (power of two, ≥2); IDXW = $clog2(NREG)
- NRD, 3, read ports
- NWR, 2, write ports; higher port number = younger instruction
- clk  in  1  clock
- rstn  in  1  reset: asynchronous, active-low; clock clk
- rd_idx  in  NRD*IDXW  read indices, port p at [p*IDXW +: IDXW]
- rd_data  out  NRD*XLEN  read data
- rd_busy  out  NRD  register at rd_idx has a pending long-latency write
- wr_en  in  NWR  write enable per port
- wr_idx  in  NWR*IDXW  write indices
- wr_data  in  NWR*XLEN  write data
- wr_clr  in  NWR  this write retires a long-latency op and clears its pending bit
- sb_set  in  1  issue of a long-latency op; mark sb_idx pending
- sb_idx  in  IDXW  destination of that op
- sb_any  out  1  OR of all pending bits (pipeline drain/flush gating)

## Operation
- Register 0 is hardwired zero. Writes to it are discarded. rd_data for it is 0. Its pending bit is never set and rd_busy for it is 0.
- Write: on the clk edge, every enabled port k with wr_idx≠0 updates reg[wr_idx[k]]. If several ports target the same index, the highest-numbered enabled port wins.
- Read: rd_data[p] = reg[rd_idx[p]] combinationally. Read ports are independent. Duplicate indices are allowed.
- Scoreboard: one pending bit per register, NREG-1 flops.
  - Set on a clk edge when sb_set=1 and sb_idx≠0.
  - Cleared on a clk edge when any port k has wr_en[k]&wr_clr[k] with wr_idx[k] equal to that index.
  - A plain write (wr_clr=0) does not touch the pending bit.
  - Simultaneous set and clear of the same index: set wins, because the new op is younger.
  - Setting an already-pending index keeps it pending.
- rd_busy[p] = pending[rd_idx[p]]. sb_any = |pending.
- Index widths are exact IDXW. NREG is a power of two, so there are no out-of-range indices.

## Timing
- Reset: all registers 0, all pending bits 0. As a result, every rd_data, rd_busy and sb_any output is 0 at reset.
- Reset asserted mid-operation clears everything asynchronously. A write or set on the deassertion edge is not taken.
- Write-to-read latency: 1 cycle without bypass (value visible after the edge). 0 cycles with bypass (see Configuration).
- Scoreboard set-to-busy: visible in the cycle after the set edge.
- Clear-to-not-busy: after the edge without bypass, same cycle with bypass.
- No handshake and no stall. All inputs are sampled every cycle.

## Configuration
- LIEAT_REGFILE_BYPASS_EN defined:
  - rd_data[p] returns the winning same-cycle wr_data (highest enabled port with wr_idx=rd_idx[p]≠0), otherwise the stored value.
  - rd_busy[p] is forced to 0 in the same cycle a clearing write to rd_idx[p] is present, unless sb_set targets the same index that cycle.
- Undefined: reads and busy reflect stored state only. This removes the comparator/mux chain from the read critical path.
- sb_any is never bypassed.

## Structure
- Package lieat_rf_pkg holds:
  - default constants LIEAT_RF_XLEN and LIEAT_RF_NREG
  - a localparam-style function rf_idxw(nreg)
  - typedef rf_idx_t
- Storage uses lieat_general_dfflr per register, with enable = OR of matching port enables and data = priority-muxed wr_data.
- Sub-module lieat_rf_sb holds the pending-bit array, set/clear priority, the busy lookup and sb_any. It is parametrised by NREG, NRD and NWR.

## Test plan
- Reset, then read all ports at idx 5 -> rd_data=0, rd_busy=0, sb_any=0. Write port0 idx 0 data 0xDEAD -> read idx 0 still 0.
- Port0 writes idx 3=0x11 and port1 writes idx 3=0x22 in the same cycle -> next cycle reads 0x22.
- sb_set idx 7 -> next cycle rd_busy=1, sb_any=1. Plain write idx 7 (wr_clr=0) -> still busy. Write idx 7 with wr_clr=1, data 0x55 -> busy drops and data 0x55 arrives: next cycle without bypass, same cycle with bypass.
- sb_set idx 9 and a clearing write to idx 9 in the same cycle -> idx 9 remains pending.
- With LIEAT_REGFILE_BYPASS_EN, write idx 4=0xABCD while rd_idx=4 -> rd_data=0xABCD in the same cycle. Without the macro -> old value that cycle, 0xABCD the next.
- Pend idx 2, write idx 2=0x1 with clear, then assert rstn low mid-cycle -> immediately all rd_data=0 and sb_any=0.
